cpu_trace_buffer: RTL
=====================

// Module: cpu_trace_buffer
// PURPOSE
//  Synthesizable trace capture for the multi-cycle CPU: records per-instruction probe
//  values (opCode, rs/rt/rd, DataOut, DataOut1, ALUOut) into a circular buffer.
//  Capture stops a programmable number of samples after an opcode trigger.
//  Sits beside CPU; a host reads the frozen trace by index, oldest first.
// PARAMETERS
//  DATA_W  32  width of DataOut/DataOut1/ALUOut
//  DEPTH   16  buffer entries; power of 2, >=2
//  ADDR_W  $clog2(DEPTH)  derived; do not override
// PORTS
//  CLK       in   1        clock, rising edge
//  RST       in   1        synchronous reset, active-high
//  smp_valid in   1        sample strobe; probe inputs valid this cycle
//  opCode    in   6        probe: opcode
//  rs,rt,rd  in   5 each   probe: register fields
//  DataOut   in   DATA_W   probe: regfile read port 1
//  DataOut1  in   DATA_W   probe: regfile read port 2
//  ALUOut    in   DATA_W   probe: ALU result
//  arm       in   1        pulse: clear trace, start capture
//  trig_op   in   6        trigger opcode
//  post_len  in   ADDR_W   samples captured after trigger sample
//  rd_idx    in   ADDR_W   readout index, 0 = oldest stored entry
//  rd_data   out  21+3*DATA_W  entry {opCode,rs,rt,rd,DataOut,DataOut1,ALUOut}
//  armed     out  1        state ARMED or POST
//  done      out  1        state DONE
//  wrapped   out  1        buffer overwritten at least once since arm
//  count     out  ADDR_W+1 stored entries, saturates at DEPTH
//  trig_pos  out  ADDR_W   trigger entry index relative to oldest
// BEHAVIOUR
//  - Reset: state IDLE; wr_ptr=0, count=0, wrapped=0, trig_pos=0, rd_data=0,
//    armed=0, done=0. Memory array not reset; content undefined until written.
//  - FSM IDLE -> ARMED on arm. ARMED/POST/DONE -> ARMED on arm (restart: wr_ptr,
//    count, wrapped, trig_pos cleared). arm beats smp_valid same cycle: sample dropped.
//  - ARMED: each smp_valid writes entry at wr_ptr, wr_ptr+1 mod DEPTH, count+1 sat;
//    wrapped set when write occurs with count==DEPTH. If opCode==trig_op on that
//    sample: latch trig_pos (position of this entry among stored, oldest=0), load
//    post_cnt=post_len, go POST; if post_len==0 go DONE directly.
//  - POST: each smp_valid writes as above, post_cnt-1; write with post_cnt==1 -> DONE.
//    Trigger compare ignored in POST. trig_pos decremented on each write that evicts
//    an entry (count==DEPTH), floor 0 (trigger evicted if post_len>=DEPTH: trig_pos=0).
//  - IDLE/DONE: no writes; smp_valid ignored.
//  - Readout: rd_data = mem[(oldest+rd_idx) mod DEPTH] registered, 1-cycle latency;
//    oldest = wrapped ? wr_ptr : 0. Valid in any state; rd_idx>=count gives undefined data.
//  - Reset mid-capture: immediate return to IDLE, trace abandoned.
// CONFIGURATION
//  TRACE_VALUE_TRIG_EN defined: adds ports trig_val (in, DATA_W) and trig_val_en (in,1);
//    trigger additionally requires ALUOut==trig_val when trig_val_en=1.
//  Undefined: ports absent; trigger is opcode match only.
// STRUCTURE
//  Package cpu_trace_pkg: state enum {IDLE,ARMED,POST,DONE}, OP_W=6, REG_W=5,
//    entry packing offsets/width function of DATA_W.
//  Sub-module trace_ram (simple dual-port, 1 write, 1 registered read, no reset).
//  Top holds FSM, pointers, counters, trigger compare.
// TESTING
//  1 RST held 2 cycles mid-ARMED after 5 samples -> armed=0, count=0, done=0 next cycle.
//  2 arm, trig_op=0x23, post_len=3, 4 samples op 0x00 then op 0x23 then 3 more ->
//    done after 8th write, count=8, trig_pos=4, rd_idx=4 returns opCode 0x23.
//  3 DEPTH=16, 20 non-trigger samples then trigger, post_len=2 -> wrapped=1, count=16,
//    rd_idx 0 = sample #8 (1-based), trig_pos=13.
//  4 trigger on first sample, post_len=0 -> done next cycle, count=1; further smp_valid
//    leaves count=1.
//  5 arm and smp_valid same cycle while DONE -> count=0, sample absent; re-arm clears trig_pos.
//  6 TRACE_VALUE_TRIG_EN, trig_val_en=1, trig_val=0x10: op match with ALUOut=0x0F no trigger,
//    ALUOut=0x10 triggers.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and entry layout for the CPU trace buffer.
// Entry packing, MSB first: {opCode, rs, rt, rd, DataOut, DataOut1, ALUOut}.
package cpu_trace_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} trace_state_e;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  function automatic int entry_w(input int data_w);
    return OP_W + 3 * REG_W + 3 * data_w;
  endfunction

  function automatic int op_lsb(input int data_w);
    return 3 * REG_W + 3 * data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port, no reset.
module trace_ram #(
  parameter int WIDTH  = 117,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of CPU probe values with opcode trigger and post-trigger count.
// Optional TRACE_VALUE_TRIG_EN adds an ALUOut value qualifier to the trigger.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      smp_valid,
  input  logic [5:0]                opCode,
  input  logic [4:0]                rs,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [DATA_W-1:0]         DataOut,
  input  logic [DATA_W-1:0]         DataOut1,
  input  logic [DATA_W-1:0]         ALUOut,
  input  logic                      arm,
  input  logic [5:0]                trig_op,
  input  logic [ADDR_W-1:0]         post_len,
  input  logic [ADDR_W-1:0]         rd_idx,
`ifdef TRACE_VALUE_TRIG_EN
  input  logic [DATA_W-1:0]         trig_val,
  input  logic                      trig_val_en,
`endif
  output logic [21+3*DATA_W-1:0]    rd_data,
  output logic                      armed,
  output logic                      done,
  output logic                      wrapped,
  output logic [ADDR_W:0]           count,
  output logic [ADDR_W-1:0]         trig_pos
);

  localparam int ENTRY_W = entry_w(DATA_W);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_POS   = ADDR_W'(DEPTH - 1);

  trace_state_e      state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              wrapped_reg;
  logic [ADDR_W-1:0] trig_pos_reg;
  logic [ADDR_W-1:0] post_cnt_reg;
  logic              rd_zero_reg;

  logic              wr_en;
  logic              full;
  logic              trig_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] ram_q;

  // arm wins over a coincident sample, so the restart begins with an empty trace
  assign wr_en = smp_valid && !arm && (state_reg == ARMED || state_reg == POST);
  assign full  = (count_reg == FULL_COUNT);
  assign wdata = {opCode, rs, rt, rd, DataOut, DataOut1, ALUOut};

`ifdef TRACE_VALUE_TRIG_EN
  assign trig_hit = (opCode == trig_op) && (!trig_val_en || (ALUOut == trig_val));
`else
  assign trig_hit = (opCode == trig_op);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      wrapped_reg  <= 1'b0;
      trig_pos_reg <= '0;
      post_cnt_reg <= '0;
    end else if (arm) begin
      state_reg    <= ARMED;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      wrapped_reg  <= 1'b0;
      trig_pos_reg <= '0;
      post_cnt_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + ONE_A;
      if (full) begin
        wrapped_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + ONE_C;
      end
      if (state_reg == ARMED) begin
        if (trig_hit) begin
          // the new entry is always the newest one after this write
          trig_pos_reg <= full ? LAST_POS : count_reg[ADDR_W-1:0];
          post_cnt_reg <= post_len;
          state_reg    <= (post_len == '0) ? DONE : POST;
        end
      end else begin
        post_cnt_reg <= post_cnt_reg - ONE_A;
        if (post_cnt_reg == ONE_A) begin
          state_reg <= DONE;
        end
        if (full && trig_pos_reg != '0) begin
          trig_pos_reg <= trig_pos_reg - ONE_A;
        end
      end
    end
  end

  // RAM output has no reset, so mask it until the first post-reset read lands
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_zero_reg <= 1'b1;
    end else begin
      rd_zero_reg <= 1'b0;
    end
  end

  assign rd_addr = (wrapped_reg ? wr_ptr_reg : '0) + rd_idx;

  trace_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  assign rd_data  = rd_zero_reg ? '0 : ram_q;
  assign armed    = (state_reg == ARMED) || (state_reg == POST);
  assign done     = (state_reg == DONE);
  assign wrapped  = wrapped_reg;
  assign count    = count_reg;
  assign trig_pos = trig_pos_reg;

endmodule
